multicycle_controller: RTL and testbench

Multicycle control unit for the 8-bit accumulator CPU. It sequences fetch, decode and execute over a byte-wide memory with a ready handshake. It drives the write enables of the datapath registers: PC (13 b), opcode (3 b), address-high (5 b), address-low (8 b), MDR (8 b) and ACC (8 b). It also drives the datapath mux selects and ALU operation. It sits between the memory interface and the register-based datapath; it holds no data itself.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_controller.sv | 121 ++++++++++++
 tb/tb_multicycle_controller.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the accumulator CPU control unit.
// States, opcodes, ALU functions and mux select encodings.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH0,
    FETCH1,
    DECODE,
    MEMRD,
    WB,
    MEMWR
  } state_t;

  typedef enum logic [2:0] {
    OP_LDA = 3'd0,
    OP_STA = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_NOT = 3'd5,
    OP_JMP = 3'd6,
    OP_JZ  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_NOT  = 3'd4
  } alu_op_t;

  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;
  localparam logic PC_INC  = 1'b0;
  localparam logic PC_JMP  = 1'b1;

  function automatic alu_op_t wb_alu(opcode_t op);
    alu_op_t r;
    r = ALU_PASS;
    unique case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Outputs are gated by rst so an aborted instruction pulses nothing.
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_src,
  output logic       pc_wen,
  output logic       pc_src,
  output logic       op_wen,
  output logic       hi_wen,
  output logic       lo_wen,
  output logic       mdr_wen,
  output logic       acc_wen,
  output logic [2:0] alu_op,
  output logic       instr_done
);

  state_t  state_q, state_d;
  opcode_t op;

  assign op = opcode_t'(opcode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_src   = ADDR_PC;
    pc_wen     = 1'b0;
    pc_src     = PC_INC;
    op_wen     = 1'b0;
    hi_wen     = 1'b0;
    lo_wen     = 1'b0;
    mdr_wen    = 1'b0;
    acc_wen    = 1'b0;
    alu_op     = ALU_PASS;
    instr_done = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH0: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            op_wen  = 1'b1;
            hi_wen  = 1'b1;
            pc_wen  = 1'b1;
            state_d = FETCH1;
          end
        end
        FETCH1: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            lo_wen  = 1'b1;
            pc_wen  = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          instr_done = 1'b1;
          state_d    = FETCH0;
          unique case (op)
            OP_JMP: begin
              pc_wen = 1'b1;
              pc_src = PC_JMP;
            end
            OP_JZ: begin
              pc_wen = acc_zero;
              pc_src = acc_zero;
            end
            OP_NOT: begin
              acc_wen = 1'b1;
              alu_op  = ALU_NOT;
            end
            OP_STA: begin
              instr_done = 1'b0;
              state_d    = MEMWR;
            end
            default: begin
              instr_done = 1'b0;
              state_d    = MEMRD;
            end
          endcase
        end
        MEMRD: begin
          mem_read = 1'b1;
          addr_src = ADDR_IR;
          if (mem_ready) begin
            mdr_wen = 1'b1;
            state_d = WB;
          end
        end
        WB: begin
          acc_wen    = 1'b1;
          alu_op     = wb_alu(op);
          instr_done = 1'b1;
          state_d    = FETCH0;
        end
        MEMWR: begin
          mem_write = 1'b1;
          addr_src  = ADDR_IR;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH0;
          end
        end
        default: state_d = FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: datapath + memory environment around the controller,
// table vectors, corner sequences and an ISA-level random model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic       acc_zero;
  logic       mem_read, mem_write, addr_src;
  logic       pc_wen, pc_src, op_wen, hi_wen, lo_wen;
  logic       mdr_wen, acc_wen, instr_done;
  logic [2:0] alu_op;

  logic [12:0] pc;
  logic [2:0]  op_r;
  logic [4:0]  hi;
  logic [7:0]  lo, mdr, acc;
  logic [7:0]  mem     [8192];
  logic [7:0]  ref_mem [8192];

  logic [12:0] m_pc;
  logic [7:0]  m_acc;

  int n_chk = 0;
  int n_fail = 0;
  int waits = 0;
  int wait_left = 0;
  bit in_acc = 0;
  bit rnd_mode = 0;
  bit done = 0;
  bit pend = 0;
  logic [2:0]  pend_v;
  logic [13:0] sig;
  logic [12:0] lo_addr;
  int wq[$];

  localparam logic [13:0] S_F0   = 14'b1_0_0_1_0_1_1_0_0_0_000_0;
  localparam logic [13:0] S_F1   = 14'b1_0_0_1_0_0_0_1_0_0_000_0;
  localparam logic [13:0] S_DEC  = 14'b0;
  localparam logic [13:0] S_RD   = 14'b1_0_1_0_0_0_0_0_1_0_000_0;
  localparam logic [13:0] S_WBL  = 14'b0_0_0_0_0_0_0_0_0_1_000_1;
  localparam logic [13:0] S_WRW  = 14'b0_1_1_0_0_0_0_0_0_0_000_0;
  localparam logic [13:0] S_WRD  = 14'b0_1_1_0_0_0_0_0_0_0_000_1;
  localparam logic [13:0] S_F0W  = 14'b1_0_0_0_0_0_0_0_0_0_000_0;

  assign acc_zero = (acc == 8'h00);

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(op_r), .acc_zero(acc_zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .addr_src(addr_src), .pc_wen(pc_wen), .pc_src(pc_src),
    .op_wen(op_wen), .hi_wen(hi_wen), .lo_wen(lo_wen),
    .mdr_wen(mdr_wen), .acc_wen(acc_wen), .alu_op(alu_op),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] cur_sig();
    return {mem_read, mem_write, addr_src, pc_wen, pc_src, op_wen,
            hi_wen, lo_wen, mdr_wen, acc_wen, alu_op, instr_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int next_wait();
    if (wq.size() > 0) return wq.pop_front();
    if (rnd_mode) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // One clock of the environment: memory handshake, then datapath update.
  task automatic cyc();
    logic [12:0] ad, n_pc;
    logic [7:0]  rd, n_lo, n_mdr, n_acc, wd;
    logic [4:0]  n_hi;
    logic [2:0]  n_op;
    logic        req, wr;
    @(negedge clk);
    req = mem_read | mem_write;
    if (req && !in_acc) begin
      wait_left = next_wait();
      in_acc = 1;
    end
    if (req) begin
      if (wait_left > 0) begin
        mem_ready = 1'b0;
        wait_left--;
        waits++;
      end else begin
        mem_ready = 1'b1;
        in_acc = 0;
      end
    end else begin
      mem_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    sig = cur_sig();
    done = instr_done;
    chk("rw_excl", {31'd0, mem_read & mem_write}, 32'd0);
    if (pend) chk("req_hold", {29'd0, mem_read, mem_write, addr_src},
                  {29'd0, pend_v});
    pend = (mem_read | mem_write) && !mem_ready;
    pend_v = {mem_read, mem_write, addr_src};
    ad = addr_src ? {hi, lo} : pc;
    rd = mem[ad];
    n_pc = pc; n_op = op_r; n_hi = hi; n_lo = lo;
    n_mdr = mdr; n_acc = acc;
    if (pc_wen) n_pc = pc_src ? {hi, lo} : pc + 13'd1;
    if (op_wen) n_op = rd[7:5];
    if (hi_wen) n_hi = rd[4:0];
    if (lo_wen) begin
      n_lo = rd;
      lo_addr = ad;
    end
    if (mdr_wen) n_mdr = rd;
    if (acc_wen) begin
      case (alu_op)
        3'd0: n_acc = mdr;
        3'd1: n_acc = acc + mdr;
        3'd2: n_acc = acc - mdr;
        3'd3: n_acc = acc & mdr;
        3'd4: n_acc = ~acc;
        default: chk("alu_op_valid", {29'd0, alu_op}, 32'd0);
      endcase
    end
    wr = mem_write && mem_ready;
    wd = acc;
    @(posedge clk);
    #1;
    pc = n_pc; op_r = n_op; hi = n_hi; lo = n_lo;
    mdr = n_mdr; acc = n_acc;
    if (wr) mem[ad] = wd;
  endtask

  task automatic run_instr(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < 40);
    if (!done) chk("instr_timeout", 32'd0, 32'd1);
  endtask

  // Instruction-level reference: whole instruction in one step.
  task automatic model_exec(output int base, output logic [12:0] a);
    logic [7:0] b0, b1, m;
    b0 = ref_mem[m_pc];
    b1 = ref_mem[13'(m_pc + 13'd1)];
    a = {b0[4:0], b1};
    m = ref_mem[a];
    m_pc = m_pc + 13'd2;
    base = 3;
    case (b0[7:5])
      3'd0: begin m_acc = m; base = 5; end
      3'd1: begin ref_mem[a] = m_acc; base = 4; end
      3'd2: begin m_acc = m_acc + m; base = 5; end
      3'd3: begin m_acc = m_acc - m; base = 5; end
      3'd4: begin m_acc = m_acc & m; base = 5; end
      3'd5: m_acc = ~m_acc;
      3'd6: m_pc = a;
      default: if (m_acc == 8'd0) m_pc = a;
    endcase
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  acc_in, m_val, exp_acc, exp_mem;
    logic [12:0] exp_pc;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n, base;
    logic [12:0] a;
    logic [13:0] got[8];
    tbl[0] = '{3'd0, 8'h33, 8'h05, 8'h05, 8'h05, 13'h102, 5};
    tbl[1] = '{3'd1, 8'h5A, 8'h11, 8'h5A, 8'h5A, 13'h102, 4};
    tbl[2] = '{3'd2, 8'h02, 8'hFF, 8'h01, 8'hFF, 13'h102, 5};
    tbl[3] = '{3'd3, 8'h00, 8'h01, 8'hFF, 8'h01, 13'h102, 5};
    tbl[4] = '{3'd4, 8'hF0, 8'h3C, 8'h30, 8'h3C, 13'h102, 5};
    tbl[5] = '{3'd5, 8'h0F, 8'h99, 8'hF0, 8'h99, 13'h102, 3};
    tbl[6] = '{3'd6, 8'h12, 8'h99, 8'h12, 8'h99, 13'h010, 3};
    tbl[7] = '{3'd7, 8'h00, 8'h99, 8'h00, 8'h99, 13'h010, 3};
    tbl[8] = '{3'd7, 8'h05, 8'h99, 8'h05, 8'h99, 13'h102, 3};

    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    pc = 13'd0; op_r = 3'd0; hi = 5'd0; lo = 8'd0;
    mdr = 8'd0; acc = 8'd0; lo_addr = 13'd0;
    rst = 1'b1;
    mem_ready = 1'b1;

    // Reset state, then the LDA walk-through from address 0.
    @(negedge clk); #1;
    chk("reset_outputs", {18'd0, cur_sig()}, 32'd0);
    mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'h41; mem[3] = 8'h23;
    mem[13'h010] = 8'h05;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      got[i] = sig;
    end
    chk("lda_f0", {18'd0, got[0]}, {18'd0, S_F0});
    chk("lda_f1", {18'd0, got[1]}, {18'd0, S_F1});
    chk("lda_dec", {18'd0, got[2]}, {18'd0, S_DEC});
    chk("lda_memrd", {18'd0, got[3]}, {18'd0, S_RD});
    chk("lda_wb", {18'd0, got[4]}, {18'd0, S_WBL});
    chk("lda_acc", {24'd0, acc}, 32'h05);
    chk("lda_pc", {19'd0, pc}, 32'h2);
    run_instr(n);

    // Opcode table, zero wait states.
    for (int i = 0; i < 9; i++) begin
      mem[13'h100] = {tbl[i].op, 5'h00};
      mem[13'h101] = 8'h10;
      mem[13'h010] = tbl[i].m_val;
      pc = 13'h100;
      acc = tbl[i].acc_in;
      run_instr(n);
      chk($sformatf("tbl%0d_cycles", i), n, tbl[i].exp_cyc);
      chk($sformatf("tbl%0d_acc", i), {24'd0, acc}, {24'd0, tbl[i].exp_acc});
      chk($sformatf("tbl%0d_pc", i), {19'd0, pc}, {19'd0, tbl[i].exp_pc});
      chk($sformatf("tbl%0d_mem", i), {24'd0, mem[13'h010]},
          {24'd0, tbl[i].exp_mem});
    end

    // STA with three wait states on the write.
    mem[13'h200] = 8'h20; mem[13'h201] = 8'h10;
    pc = 13'h200; acc = 8'h77;
    wq = '{0, 0, 3};
    for (int i = 0; i < 7; i++) begin
      cyc();
      got[i] = sig;
    end
    chk("sta_f0", {18'd0, got[0]}, {18'd0, S_F0});
    chk("sta_f1", {18'd0, got[1]}, {18'd0, S_F1});
    chk("sta_dec", {18'd0, got[2]}, {18'd0, S_DEC});
    for (int i = 3; i < 6; i++)
      chk($sformatf("sta_wait%0d", i - 3), {18'd0, got[i]}, {18'd0, S_WRW});
    chk("sta_done", {18'd0, got[6]}, {18'd0, S_WRD});
    chk("sta_mem", {24'd0, mem[13'h010]}, 32'h77);

    // Fetch straddling the top of memory.
    mem[13'h1FFF] = 8'hC3; mem[0] = 8'h44;
    pc = 13'h1FFF;
    run_instr(n);
    chk("wrap_lo_addr", {19'd0, lo_addr}, 32'h0);
    chk("wrap_jmp_pc", {19'd0, pc}, 32'h344);
    mem[13'h1FFF] = 8'hA0;
    pc = 13'h1FFF; acc = 8'h3C;
    run_instr(n);
    chk("wrap_inc_pc", {19'd0, pc}, 32'h1);
    chk("wrap_not_acc", {24'd0, acc}, 32'hC3);

    // Reset asserted in MEMRD while the read completes.
    mem[13'h300] = 8'h00; mem[13'h301] = 8'h10; mem[13'h302] = 8'hA0;
    mem[13'h010] = 8'hAB;
    pc = 13'h300; acc = 8'h11;
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rst_in_memrd", {29'd0, mem_read, addr_src, mdr_wen}, 32'h7);
    rst = 1'b1;
    #1;
    chk("rst_async_zero", {18'd0, cur_sig()}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_hold%0d", i), {18'd0, cur_sig()}, 32'd0);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    in_acc = 0;
    pend = 0;
    #1;
    chk("rst_release_f0", {18'd0, cur_sig()}, {18'd0, S_F0W});
    run_instr(n);
    chk("rst_restart_cycles", n, 3);
    chk("rst_restart_acc", {24'd0, acc}, 32'hEE);

    // Random program with random wait states against the ISA model.
    rnd_mode = 1;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ref_mem[i] = mem[i];
    end
    pc = 13'($urandom);
    acc = 8'($urandom);
    m_pc = pc;
    m_acc = acc;
    for (int k = 0; k < 300; k++) begin
      waits = 0;
      model_exec(base, a);
      run_instr(n);
      chk("rnd_cycles", n, base + waits);
      chk("rnd_pc", {19'd0, pc}, {19'd0, m_pc});
      chk("rnd_acc", {24'd0, acc}, {24'd0, m_acc});
      chk("rnd_mem", {24'd0, mem[a]}, {24'd0, ref_mem[a]});
      m_pc = pc;
      m_acc = acc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
